// File: rtl/nabp_shifter_control.sv
// ----------------------------------------------------------------------------
// nabp_shifter_control
//
// Sequences one projection sweep of the NABP shifter. For every angle it
// kicks a fill, waits for the shifter to report fill complete, waits for the
// downstream datapath to be ready, kicks a shift, and waits for shift
// complete. After the last angle it pulses sweep_done and returns to IDLE.
// Waits on the shifter are guarded by a timeout that parks the block in a
// sticky ERROR state until the next start.
//
// Parameters
//   kAngleLength : projection angles per sweep
//   kTimeout     : max wait cycles for a shifter done (0 = no timeout)
//
// Ports
//   clk           in   sole clock, rising edge
//   reset         in   asynchronous, active-high reset
//   start         in   begin a sweep (honoured only in IDLE and ERROR)
//   abort         in   cancel the sweep in progress
//   pe_ready      in   downstream datapath can accept a shift phase
//   sh_fill_done  in   fill-complete level from the shifter
//   sh_shift_done in   shift-complete level from the shifter
//   sh_fill_kick  out  one-cycle fill request
//   sh_shift_kick out  one-cycle shift request
//   angle         out  current angle index
//   busy          out  sweep in progress
//   sweep_done    out  one-cycle pulse after the last angle completes
//   error         out  sticky timeout flag
// ----------------------------------------------------------------------------
module nabp_shifter_control #(
    parameter int kAngleLength = 180,
    parameter int kTimeout     = 4096,
    localparam int AngleWidth  = (kAngleLength > 1) ? $clog2(kAngleLength) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pe_ready,
    input  logic                  sh_fill_done,
    input  logic                  sh_shift_done,
    output logic                  sh_fill_kick,
    output logic                  sh_shift_kick,
    output logic [AngleWidth-1:0] angle,
    output logic                  busy,
    output logic                  sweep_done,
    output logic                  error
);

    localparam int CountWidth = (kTimeout > 0) ? $clog2(kTimeout + 1) : 1;
    localparam logic [AngleWidth-1:0] LastAngle   = AngleWidth'(kAngleLength - 1);
    localparam logic [CountWidth-1:0] TimeoutLast = CountWidth'(kTimeout - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL_KICK,
        FILL_WAIT,
        READY_WAIT,
        SHIFT_KICK,
        SHIFT_WAIT,
        SWEEP_DONE,
        ERROR
    } state_t;

    state_t                  state_reg, state_next;
    logic [AngleWidth-1:0]   angle_reg, angle_next;
    logic [CountWidth-1:0]   count_reg, count_next;
    logic                    in_sweep;
    logic                    timed_out;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            angle_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            angle_reg <= angle_next;
            count_reg <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        angle_next = angle_reg;
        count_next = count_reg;

        in_sweep = (state_reg != IDLE) && (state_reg != ERROR);

        // count_reg holds the number of wait cycles already completed, so the
        // current cycle is the kTimeout-th one when it equals kTimeout-1. A
        // done seen in that same cycle is checked first and therefore wins.
        timed_out = (kTimeout != 0) && (count_reg == TimeoutLast);

        if (abort && in_sweep) begin
            // Abort outranks any done, pe_ready or timeout in the same cycle.
            state_next = IDLE;
            angle_next = '0;
            count_next = '0;
        end else begin
            unique case (state_reg)
                IDLE, ERROR: begin
                    if (start) begin
                        state_next = FILL_KICK;
                        angle_next = '0;
                    end
                end
                FILL_KICK: begin
                    state_next = FILL_WAIT;
                    count_next = '0;
                end
                FILL_WAIT: begin
                    if (sh_fill_done) begin
                        state_next = READY_WAIT;
                    end else if (timed_out) begin
                        state_next = ERROR;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
                READY_WAIT: begin
                    if (pe_ready) begin
                        state_next = SHIFT_KICK;
                    end
                end
                SHIFT_KICK: begin
                    state_next = SHIFT_WAIT;
                    count_next = '0;
                end
                SHIFT_WAIT: begin
                    if (sh_shift_done) begin
                        if (angle_reg == LastAngle) begin
                            state_next = SWEEP_DONE;
                        end else begin
                            state_next = FILL_KICK;
                            angle_next = angle_reg + 1'b1;
                        end
                    end else if (timed_out) begin
                        state_next = ERROR;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
                SWEEP_DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        sh_fill_kick  = (state_reg == FILL_KICK);
        sh_shift_kick = (state_reg == SHIFT_KICK);
        sweep_done    = (state_reg == SWEEP_DONE);
        error         = (state_reg == ERROR);
        busy          = (state_reg != IDLE) && (state_reg != ERROR);
        angle         = angle_reg;
    end

endmodule

// File: tb/tb_nabp_shifter_control.sv
// ----------------------------------------------------------------------------
// tb_nabp_shifter_control
//
// Self-checking bench for nabp_shifter_control (kAngleLength=4, kTimeout=8).
// A small shifter model answers kicks after per-angle delays; a timeline model
// predicts kick and sweep_done cycles from those delays with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_nabp_shifter_control;

    localparam int NA = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       pe_ready = 1'b1;
    logic       sh_fill_done = 1'b0;
    logic       sh_shift_done = 1'b0;
    logic       sh_fill_kick;
    logic       sh_shift_kick;
    logic [1:0] angle;
    logic       busy;
    logic       sweep_done;
    logic       error;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Per-angle shifter delays: fill done visible fd cycles after the fill
    // kick, pe_ready visible pr cycles after the fill kick, shift done visible
    // sd cycles after the shift kick.
    int fd_a[NA];
    int pr_a[NA];
    int sd_a[NA];
    int ef[NA];
    int es[NA];
    int ed;

    int lfk = -1000;
    int lsk = -1000;
    int fd_cur = 1;
    int pr_cur = 0;
    int sd_cur = 1;
    bit hold_fill = 1'b0;
    bit noise = 1'b0;

    int fk_c[$];
    int fk_a[$];
    int sk_c[$];
    int sk_a[$];
    int sd_c[$];
    int err_c = -1;

    nabp_shifter_control #(
        .kAngleLength(NA),
        .kTimeout(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .pe_ready(pe_ready),
        .sh_fill_done(sh_fill_done),
        .sh_shift_done(sh_shift_done),
        .sh_fill_kick(sh_fill_kick),
        .sh_shift_kick(sh_shift_kick),
        .angle(angle),
        .busy(busy),
        .sweep_done(sweep_done),
        .error(error)
    );

    always #5 clk = ~clk;

    // One clock: observe outputs 1 time unit after the edge, then drive the
    // shifter model and one-shot inputs for the coming cycle.
    task automatic step();
        int k;
        @(posedge clk);
        #1;
        cyc++;
        if (sh_fill_kick === 1'b1) begin
            k = fk_c.size();
            if (k > NA - 1) k = NA - 1;
            fk_c.push_back(cyc);
            fk_a.push_back(int'(angle));
            lfk = cyc;
            fd_cur = fd_a[k];
            pr_cur = pr_a[k];
        end
        if (sh_shift_kick === 1'b1) begin
            k = sk_c.size();
            if (k > NA - 1) k = NA - 1;
            sk_c.push_back(cyc);
            sk_a.push_back(int'(angle));
            lsk = cyc;
            sd_cur = sd_a[k];
        end
        if (sweep_done === 1'b1) sd_c.push_back(cyc);
        if (error === 1'b1 && err_c < 0) err_c = cyc;
        sh_fill_done  = hold_fill || (cyc >= lfk + fd_cur);
        pe_ready      = (cyc >= lfk + pr_cur);
        sh_shift_done = (cyc >= lsk + sd_cur);
        start = noise && (busy === 1'b1) && ($urandom_range(0, 1) == 1);
        abort = 1'b0;
    endtask

    // Expected timeline for a sweep whose start is visible in cycle s0.
    task automatic predict(input int s0);
        int t;
        int a_rdy;
        int b_rdy;
        t = s0 + 1;
        for (int a = 0; a < NA; a++) begin
            ef[a] = t;
            a_rdy = t + fd_a[a] + 1;   // first READY_WAIT cycle
            b_rdy = t + pr_a[a];       // first cycle pe_ready is high
            es[a] = ((a_rdy > b_rdy) ? a_rdy : b_rdy) + 1;
            t = es[a] + sd_a[a] + 1;
        end
        ed = t;
    endtask

    task automatic begin_sweep();
        fk_c.delete(); fk_a.delete(); sk_c.delete(); sk_a.delete(); sd_c.delete();
        err_c = -1;
        start = 1'b1;
        predict(cyc);
        step();
    endtask

    task automatic run_sweep(input int budget);
        int n;
        begin_sweep();
        n = 0;
        while (sd_c.size() == 0 && err_c < 0 && n < budget) begin
            step();
            n++;
        end
        step();
        $display("sweep: fills=%0d shifts=%0d done_pulses=%0d err_cycle=%0d end_cycle=%0d",
                 fk_c.size(), sk_c.size(), sd_c.size(), err_c, cyc);
    endtask

    task automatic set_delays(input int fd, input int pr, input int sd);
        for (int a = 0; a < NA; a++) begin
            fd_a[a] = fd; pr_a[a] = pr; sd_a[a] = sd;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || angle !== 2'd0) begin
            errors++;
            $display("FAIL reset_busy_angle: got busy=%b angle=%0d expected 0 0", busy, angle);
        end
        checks++;
        if ({sh_fill_kick, sh_shift_kick, sweep_done, error} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {sh_fill_kick, sh_shift_kick, sweep_done, error});
        end
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b error=%b expected 0 0", busy, error);
        end
    endtask

    // Sweep 0 is the 5-cycle shifter with pe_ready high; the rest are
    // randomized and issued back to back with start noise while busy.
    task automatic test_sweeps();
        for (int s = 0; s < 7; s++) begin
            for (int a = 0; a < NA; a++) begin
                if (s == 0) begin
                    fd_a[a] = 5; pr_a[a] = 0; sd_a[a] = 5;
                end else begin
                    fd_a[a] = $urandom_range(1, 8);
                    pr_a[a] = $urandom_range(0, 12);
                    sd_a[a] = $urandom_range(1, 8);
                end
            end
            noise = (s > 0);
            run_sweep(500);
            checks++;
            if (fk_c.size() != NA || sk_c.size() != NA) begin
                errors++;
                $display("FAIL sweep%0d_kick_count: got fill=%0d shift=%0d expected %0d",
                         s, fk_c.size(), sk_c.size(), NA);
            end
            for (int a = 0; a < NA; a++) begin
                if (fk_c.size() > a) begin
                    checks++;
                    if (fk_c[a] != ef[a] || fk_a[a] != a) begin
                        errors++;
                        $display("FAIL sweep%0d_fill%0d: got cycle=%0d angle=%0d expected %0d %0d",
                                 s, a, fk_c[a], fk_a[a], ef[a], a);
                    end
                end
                if (sk_c.size() > a) begin
                    checks++;
                    if (sk_c[a] != es[a] || sk_a[a] != a) begin
                        errors++;
                        $display("FAIL sweep%0d_shift%0d: got cycle=%0d angle=%0d expected %0d %0d",
                                 s, a, sk_c[a], sk_a[a], es[a], a);
                    end
                end
            end
            checks++;
            if (sd_c.size() != 1 || sd_c[0] != ed) begin
                errors++;
                $display("FAIL sweep%0d_done: got pulses=%0d cycle=%0d expected 1 %0d",
                         s, sd_c.size(), (sd_c.size() > 0) ? sd_c[0] : -1, ed);
            end
            checks++;
            if (busy !== 1'b0 || angle !== 2'd3 || err_c != -1) begin
                errors++;
                $display("FAIL sweep%0d_after: got busy=%b angle=%0d err_cycle=%0d expected 0 3 -1",
                         s, busy, angle, err_c);
            end
        end
        noise = 1'b0;
    endtask

    task automatic test_backpressure();
        set_delays(2, 0, 2);
        fd_a[0] = 3;
        pr_a[0] = 24;   // pe_ready low for 20 cycles after fill_done is taken
        run_sweep(500);
        checks++;
        if (fk_c.size() < 1 || sk_c.size() < 1 || sk_c[0] != fk_c[0] + 25) begin
            errors++;
            $display("FAIL backpressure_shift_kick: got %0d expected %0d",
                     (sk_c.size() > 0) ? sk_c[0] : -1, (fk_c.size() > 0) ? fk_c[0] + 25 : -1);
        end
        checks++;
        if (err_c != -1 || sd_c.size() != 1 || sd_c[0] != ed) begin
            errors++;
            $display("FAIL backpressure_completion: got err_cycle=%0d pulses=%0d expected -1 1",
                     err_c, sd_c.size());
        end
    endtask

    task automatic test_timeout();
        // Done exactly on the 8th wait cycle must beat the timeout.
        set_delays(8, 0, 8);
        run_sweep(500);
        checks++;
        if (err_c != -1 || sd_c.size() != 1 || sd_c[0] != ed) begin
            errors++;
            $display("FAIL timeout_boundary_win: got err_cycle=%0d pulses=%0d expected -1 1",
                     err_c, sd_c.size());
        end
        // Fill done one cycle too late.
        set_delays(9, 0, 2);
        run_sweep(100);
        checks++;
        if (fk_c.size() < 1 || err_c != fk_c[0] + 9) begin
            errors++;
            $display("FAIL timeout_fill: got err_cycle=%0d expected %0d",
                     err_c, (fk_c.size() > 0) ? fk_c[0] + 9 : -1);
        end
        // Shift done never arrives.
        set_delays(2, 0, 1000);
        run_sweep(100);
        checks++;
        if (sk_c.size() != 1 || err_c != sk_c[0] + 9) begin
            errors++;
            $display("FAIL timeout_shift: got err_cycle=%0d shifts=%0d expected %0d 1",
                     err_c, sk_c.size(), (sk_c.size() > 0) ? sk_c[0] + 9 : -1);
        end
        for (int i = 0; i < 3; i++) begin
            abort = 1'b1;
            step();
        end
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got error=%b busy=%b expected 1 0", error, busy);
        end
        start = 1'b1;
        step();
        checks++;
        if (error !== 1'b0 || sh_fill_kick !== 1'b1 || angle !== 2'd0) begin
            errors++;
            $display("FAIL timeout_restart: got error=%b fill_kick=%b angle=%0d expected 0 1 0",
                     error, sh_fill_kick, angle);
        end
        abort = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || sh_fill_kick !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_fill_kick: got busy=%b fill_kick=%b expected 0 0",
                     busy, sh_fill_kick);
        end
    endtask

    task automatic test_abort();
        int n;
        set_delays(2, 0, 3);
        begin_sweep();
        n = 0;
        while (cyc < es[2] + 3 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (angle !== 2'd2 || sh_shift_done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: got angle=%0d shift_done=%b busy=%b expected 2 1 1",
                     angle, sh_shift_done, busy);
        end
        abort = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || angle !== 2'd0 || sh_fill_kick !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b angle=%0d fill_kick=%b expected 0 0 0",
                     busy, angle, sh_fill_kick);
        end
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (fk_c.size() != 3 || sk_c.size() != 3 || sd_c.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got fills=%0d shifts=%0d done=%0d busy=%b expected 3 3 0 0",
                     fk_c.size(), sk_c.size(), sd_c.size(), busy);
        end
        // Abort is ignored in IDLE, so start alongside it still launches.
        start = 1'b1;
        abort = 1'b1;
        step();
        checks++;
        if (sh_fill_kick !== 1'b1 || angle !== 2'd0) begin
            errors++;
            $display("FAIL abort_ignored_idle: got fill_kick=%b angle=%0d expected 1 0",
                     sh_fill_kick, angle);
        end
        abort = 1'b1;
        step();
    endtask

    task automatic test_done_ignored();
        hold_fill = 1'b1;
        step(); step(); step();
        checks++;
        if (busy !== 1'b0 || sh_fill_kick !== 1'b0) begin
            errors++;
            $display("FAIL done_ignored_idle: got busy=%b fill_kick=%b expected 0 0", busy, sh_fill_kick);
        end
        // A done held through the kick cycle behaves like fd=1.
        set_delays(1, 0, 2);
        noise = 1'b1;
        run_sweep(300);
        noise = 1'b0;
        hold_fill = 1'b0;
        for (int a = 0; a < NA; a++) begin
            checks++;
            if (fk_c.size() <= a || sk_c.size() <= a || sk_c[a] != fk_c[a] + 3) begin
                errors++;
                $display("FAIL done_ignored_shift%0d: got %0d expected %0d", a,
                         (sk_c.size() > a) ? sk_c[a] : -1, (fk_c.size() > a) ? fk_c[a] + 3 : -1);
            end
        end
        checks++;
        if (sd_c.size() != 1 || sd_c[0] != ed) begin
            errors++;
            $display("FAIL done_ignored_sweep: got pulses=%0d expected 1", sd_c.size());
        end
    endtask

    task automatic test_async_reset();
        int n;
        set_delays(6, 0, 2);
        begin_sweep();
        n = 0;
        while (cyc < ef[2] + 2 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (angle !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_setup: got angle=%0d busy=%b expected 2 1", angle, busy);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || angle !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_immediate: got busy=%b angle=%0d expected 0 0", busy, angle);
        end
        checks++;
        if ({sh_fill_kick, sh_shift_kick, sweep_done, error} !== 4'b0) begin
            errors++;
            $display("FAIL async_reset_flags: got %b expected 0000",
                     {sh_fill_kick, sh_shift_kick, sweep_done, error});
        end
        step();
        reset = 1'b0;
        set_delays(2, 1, 2);
        run_sweep(300);
        checks++;
        if (fk_c.size() < 1 || fk_a[0] != 0 || fk_c[0] != ef[0]) begin
            errors++;
            $display("FAIL async_reset_restart: got fills=%0d first_angle=%0d expected angle 0",
                     fk_c.size(), (fk_a.size() > 0) ? fk_a[0] : -1);
        end
        checks++;
        if (sd_c.size() != 1 || sd_c[0] != ed) begin
            errors++;
            $display("FAIL async_reset_sweep: got pulses=%0d expected 1", sd_c.size());
        end
    endtask

    initial begin
        set_delays(1, 0, 1);
        test_reset();
        test_sweeps();
        test_backpressure();
        test_timeout();
        test_abort();
        test_done_ignored();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop so a wedged run still ends.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nabp_shifter_control.md
NABP_SHIFTER_CONTROL -- requirements
Module: nabp_shifter_control

Interface
REQ-001 The block SHALL have parameter kAngleLength, default 180, giving the number of projection angles per sweep.
REQ-002 The block SHALL have parameter kTimeout, default 4096, giving the maximum wait cycles for a shifter done; 0 disables the timeout.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1 bit: sole clock, rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port start, input, 1 bit: begin a sweep; sampled only in IDLE and ERROR.
REQ-007 Port abort, input, 1 bit: cancel the sweep in progress.
REQ-008 Port pe_ready, input, 1 bit: downstream datapath can accept a shift phase.
REQ-009 Port sh_fill_done, input, 1 bit: fill-complete level from the shifter.
REQ-010 Port sh_shift_done, input, 1 bit: shift-complete level from the shifter.
REQ-011 Port sh_fill_kick, output, 1 bit: one-cycle fill request to the shifter.
REQ-012 Port sh_shift_kick, output, 1 bit: one-cycle shift request to the shifter.
REQ-013 Port angle, output, clog2(kAngleLength) bits: current angle index, unsigned.
REQ-014 Port busy, output, 1 bit: sweep in progress.
REQ-015 Port sweep_done, output, 1 bit: one-cycle pulse after the last angle completes.
REQ-016 Port error, output, 1 bit: sticky timeout flag.

Function
REQ-017 All outputs SHALL be registered, i.e. Moore outputs decoded from the registered state.
REQ-018 States SHALL be IDLE, FILL_KICK, FILL_WAIT, READY_WAIT, SHIFT_KICK, SHIFT_WAIT, SWEEP_DONE and ERROR.
REQ-019 IDLE: start=1 SHALL set angle=0 and go to FILL_KICK.
REQ-020 FILL_KICK: sh_fill_kick SHALL be 1 for exactly this one cycle, then the state SHALL go to FILL_WAIT.
REQ-021 FILL_WAIT: sh_fill_done=1 SHALL go to READY_WAIT; sh_fill_done is ignored in every other state, including the kick cycle.
REQ-022 READY_WAIT: pe_ready=1 SHALL go to SHIFT_KICK; there is no timeout in this state.
REQ-023 SHIFT_KICK: sh_shift_kick SHALL be 1 for exactly one cycle, then the state SHALL go to SHIFT_WAIT.
REQ-024 SHIFT_WAIT, sh_shift_done=1: if angle==kAngleLength-1 the state SHALL go to SWEEP_DONE; otherwise angle SHALL increment by 1 and the state SHALL go to FILL_KICK.
REQ-025 SWEEP_DONE: sweep_done SHALL be 1 for one cycle, then the state SHALL go to IDLE; angle holds its last value.
REQ-026 busy SHALL be 1 in every state except IDLE and ERROR.
REQ-027 Latency: with the shifter done and pe_ready already high, the cycle after start has sh_fill_kick=1, and sh_shift_kick follows 2 cycles after fill_done is sampled.
REQ-028 The timeout counter SHALL clear on entry to FILL_WAIT and SHIFT_WAIT, and increment each cycle spent in those states.
REQ-029 With kTimeout>0, reaching count==kTimeout without a done SHALL go to ERROR and set error=1.
REQ-030 A done arriving in the same cycle the count reaches kTimeout SHALL win, with no error.
REQ-031 ERROR: error SHALL hold at 1; start=1 SHALL clear error, set angle=0 and go to FILL_KICK.
REQ-032 abort=1 in any busy state SHALL go to IDLE next cycle with angle=0 and no kick issued.
REQ-033 abort SHALL take priority over a simultaneous done, pe_ready or timeout.
REQ-034 abort SHALL be ignored in IDLE and ERROR.
REQ-035 start while busy SHALL be ignored.
REQ-036 The angle counter SHALL never exceed kAngleLength-1 and SHALL never wrap.

Reset
REQ-037 Asserting reset SHALL immediately force state IDLE and set all outputs, angle, error and the timeout counter to 0, regardless of clock.
REQ-038 Reset mid-sweep SHALL discard progress; the first start after release begins again at angle 0.

Verification
REQ-039 Scenario, normal sweep: kAngleLength=4, shifter model asserts done 5 cycles after each kick, pe_ready=1 -> 4 fill and 4 shift kicks, angle sequence 0,1,2,3, one sweep_done pulse, busy low afterward.
REQ-040 Scenario, backpressure: pe_ready=0 for 20 cycles after fill_done -> state held in READY_WAIT, no shift kick, no error; shift kick exactly 1 cycle after pe_ready rises.
REQ-041 Scenario, timeout: kTimeout=8, sh_shift_done never asserted -> error=1 and busy=0 after 8 SHIFT_WAIT cycles; a new start clears error and sh_fill_kick appears with angle=0.
REQ-042 Scenario, abort: abort and sh_shift_done both high at angle 2 -> IDLE, angle=0, no further kick, no sweep_done.
REQ-043 Scenario, reset: reset asserted asynchronously mid-FILL_WAIT -> all outputs 0 before the next clock edge; start then restarts at angle 0.
REQ-044 Scenario, done ignored: sh_fill_done held high during IDLE and the FILL_KICK cycle -> no state advance until FILL_WAIT; start pulses while busy have no effect.
